// File: rtl/regfile_multiport_if.sv
// Write/read bus of the multiport register file.
// The master drives the write and read addresses; the slave returns read data and write status.
interface regfile_multiport_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
) ();
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_pending;

  modport master (
    output we, waddr, wdata, rd_addr,
    input  rd_data, wr_pending
  );

  modport slave (
    input  we, waddr, wdata, rd_addr,
    output rd_data, wr_pending
  );
endinterface

// File: rtl/regfile_multiport.sv
// DEPTH x DATA_W register file with NUM_RD registered-address read ports and one
// write port that commits one cycle after it is staged, with optional forwarding.
module regfile_multiport #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
  input logic             clk,
  input logic             reset,
  regfile_multiport_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              wv_reg;
  logic [ADDR_W-1:0] wa_reg;
  logic [DATA_W-1:0] wd_reg;
  logic              wv_next;

  // Writes aimed at a hard-wired zero register never enter the stage.
  assign wv_next = bus.we && !(ZERO_REG && (bus.waddr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wv_reg <= 1'b0;
      wa_reg <= '0;
      wd_reg <= '0;
    end else begin
      wv_reg <= wv_next;
      wa_reg <= bus.waddr;
      wd_reg <= bus.wdata;
      if (wv_reg) begin
        mem_reg[wa_reg] <= wd_reg;
      end
    end
  end

  assign bus.wr_pending = wv_reg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] raddr_reg;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge clk) begin
      if (reset) begin
        raddr_reg <= '0;
      end else begin
        raddr_reg <= bus.rd_addr[gi*ADDR_W +: ADDR_W];
      end
    end

    // Lowest priority first so the zero register overrides any forwarded data.
    always_comb begin
      rd_word = mem_reg[raddr_reg];
      if (BYPASS && wv_reg && (wa_reg == raddr_reg)) begin
        rd_word = wd_reg;
      end
      if (ZERO_REG && (raddr_reg == '0)) begin
        rd_word = '0;
      end
    end

    assign bus.rd_data[gi*DATA_W +: DATA_W] = rd_word;
  end
endmodule
